// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and helpers for the BCD down-counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // A wrap value is usable only if both nibbles are legal decimal digits.
  function automatic bit wrap_val_ok(input logic [7:0] val);
    return (val[7:4] <= BCD_MAX) && (val[3:0] <= BCD_MAX);
  endfunction

  function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade down-counter: load with clamp, enable-driven decrement, borrow-out.
module bcd_digit_down
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  bcd_digit_t load_val_i,
  input  logic       en_i,
  output bcd_digit_t q_o,
  output logic       bo_o
);

  bcd_digit_t digit_q, digit_d;

  // Zero and any illegal code both roll to 9, so a corrupted digit self-heals.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = clamp_digit(load_val_i);
    end else if (en_i) begin
      if ((digit_q == BCD_ZERO) || (digit_q > BCD_MAX)) begin
        digit_d = BCD_MAX;
      end else begin
        digit_d = digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q_o  = digit_q;
  assign bo_o = en_i & (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Two-digit cascadable BCD down-counter with 74160-style enables, borrow outputs
// and a one-cycle DONE pulse when the count reaches 00.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter logic [7:0] WRAP_VAL    = 8'h20,
  parameter bit         AUTO_RELOAD = 1'b1
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       LOAD,
  input  logic [3:0] DATA0,
  input  logic [3:0] DATA1,
  input  logic       ENP,
  input  logic       ENT,
  output logic [3:0] Q0,
  output logic [3:0] Q1,
  output logic [7:0] Q,
  output logic       BO1,
  output logic       BO2,
  output logic       DONE
);

  if (!wrap_val_ok(WRAP_VAL)) begin : gBadWrapVal
    $error("bcd_down_counter: WRAP_VAL nibbles must each be <= 9");
  end

  bcd_digit_t clamp1, clamp0;
  bcd_digit_t ones, tens;
  logic [7:0] clampVal, loadVal, digitVal;
  logic       cnt, atZero, holdStop;
  logic       onesEn, onesBo, tensBo, digitLoad;
  logic       done_q, done_d;

  // BCD digits order like binary, so a plain magnitude compare limits the load.
  assign clamp1   = clamp_digit(DATA1);
  assign clamp0   = clamp_digit(DATA0);
  assign clampVal = {clamp1, clamp0};
  assign loadVal  = (clampVal > WRAP_VAL) ? WRAP_VAL : clampVal;

  assign cnt      = ENP & ENT & ~LOAD;
  assign atZero   = ({tens, ones} == 8'h00);
  assign holdStop = ~AUTO_RELOAD & atZero;
  assign onesEn   = cnt & ~holdStop;

  // A borrow out of the tens digit is the terminal count; it reloads WRAP_VAL
  // through the digits' load path, which overrides their own decrement.
  assign digitLoad = LOAD | tensBo;
  assign digitVal  = LOAD ? loadVal : WRAP_VAL;

  bcd_digit_down uOnes (
    .clk_i      (CLK),
    .rst_ni     (CLR_N),
    .load_i     (digitLoad),
    .load_val_i (digitVal[3:0]),
    .en_i       (onesEn),
    .q_o        (ones),
    .bo_o       (onesBo)
  );

  bcd_digit_down uTens (
    .clk_i      (CLK),
    .rst_ni     (CLR_N),
    .load_i     (digitLoad),
    .load_val_i (digitVal[7:4]),
    .en_i       (onesBo),
    .q_o        (tens),
    .bo_o       (tensBo)
  );

  assign done_d = cnt & ({tens, ones} == 8'h01);

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign Q0   = ones;
  assign Q1   = tens;
  assign Q    = {tens, ones};
  assign BO1  = ENT & (ones == BCD_ZERO);
  assign BO2  = ENT & atZero;
  assign DONE = done_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: one auto-reload and one hold-at-zero
// instance share stimulus; a decimal reference model feeds a scoreboard queue.
module tb_bcd_down_counter;

  localparam int WRAP_INT = 20;

  logic       CLK, CLR_N, LOAD, ENP, ENT;
  logic [3:0] DATA0, DATA1;

  logic [3:0] q0R, q1R, q0H, q1H;
  logic [7:0] qR, qH;
  logic       bo1R, bo2R, doneR, bo1H, bo2H, doneH;

  bcd_down_counter #(.WRAP_VAL(8'h20), .AUTO_RELOAD(1'b1)) dutR (
    .CLK(CLK), .CLR_N(CLR_N), .LOAD(LOAD), .DATA0(DATA0), .DATA1(DATA1),
    .ENP(ENP), .ENT(ENT), .Q0(q0R), .Q1(q1R), .Q(qR),
    .BO1(bo1R), .BO2(bo2R), .DONE(doneR)
  );

  bcd_down_counter #(.WRAP_VAL(8'h20), .AUTO_RELOAD(1'b0)) dutH (
    .CLK(CLK), .CLR_N(CLR_N), .LOAD(LOAD), .DATA0(DATA0), .DATA1(DATA1),
    .ENP(ENP), .ENT(ENT), .Q0(q0H), .Q1(q1H), .Q(qH),
    .BO1(bo1H), .BO2(bo2H), .DONE(doneH)
  );

  typedef struct {
    int   valR;
    int   valH;
    logic doneR;
    logic doneH;
    logic ent;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   mR = 0;
  int   mH = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] toBcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int nextVal(input int m, input logic ld, input logic [3:0] d1,
                                 input logic [3:0] d0, input logic enp, input logic ent,
                                 input bit autoReload);
    int c1, c0, v;
    if (ld) begin
      c1 = (d1 > 4'd9) ? 9 : int'(d1);
      c0 = (d0 > 4'd9) ? 9 : int'(d0);
      v  = c1 * 10 + c0;
      return (v > WRAP_INT) ? WRAP_INT : v;
    end
    if (enp && ent) begin
      if (m == 0) return autoReload ? WRAP_INT : 0;
      return m - 1;
    end
    return m;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [7:0] bR, bH;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e  = sb.pop_front();
    bR = toBcd(e.valR);
    bH = toBcd(e.valH);
    cmp("Q_reload", qR, bR);
    cmp("Q1Q0_reload", {q1R, q0R}, bR);
    cmp("DONE_reload", {7'd0, doneR}, {7'd0, e.doneR});
    cmp("BO1_reload", {7'd0, bo1R}, {7'd0, e.ent & (bR[3:0] == 4'd0)});
    cmp("BO2_reload", {7'd0, bo2R}, {7'd0, e.ent & (bR == 8'h00)});
    cmp("Q_hold", qH, bH);
    cmp("Q1Q0_hold", {q1H, q0H}, bH);
    cmp("DONE_hold", {7'd0, doneH}, {7'd0, e.doneH});
    cmp("BO1_hold", {7'd0, bo1H}, {7'd0, e.ent & (bH[3:0] == 4'd0)});
    cmp("BO2_hold", {7'd0, bo2H}, {7'd0, e.ent & (bH == 8'h00)});
  endtask

  task automatic applyStimulus(input logic ld, input logic [3:0] d1, input logic [3:0] d0,
                               input logic enp, input logic ent);
    exp_t e;
    LOAD  = ld;
    DATA1 = d1;
    DATA0 = d0;
    ENP   = enp;
    ENT   = ent;
    e.doneR = !ld && enp && ent && (mR == 1);
    e.doneH = !ld && enp && ent && (mH == 1);
    mR = nextVal(mR, ld, d1, d0, enp, ent, 1'b1);
    mH = nextVal(mH, ld, d1, d0, enp, ent, 1'b0);
    e.valR = mR;
    e.valH = mH;
    e.ent  = ent;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  initial begin
    CLR_N = 1'b0;
    LOAD  = 1'b0;
    DATA0 = 4'd0;
    DATA1 = 4'd0;
    ENP   = 1'b0;
    ENT   = 1'b0;
    #2;
    cmp("reset_Q_reload", qR, 8'h00);
    cmp("reset_DONE_reload", {7'd0, doneR}, 8'h00);
    cmp("reset_Q_hold", qH, 8'h00);
    @(posedge CLK);
    #1;
    CLR_N = 1'b1;

    $display("[TB] load 12 then count down through zero");
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cmp("wrap_to_start", qR, 8'h20);
    cmp("hold_at_zero", qH, 8'h00);

    $display("[TB] keep counting: reload instance runs on, hold instance stays at 00");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cmp("hold_no_done", {7'd0, doneH}, 8'h00);

    $display("[TB] enable gating at 00");
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    cmp("enp_low_BO2", {7'd0, bo2R}, 8'h01);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    cmp("ent_low_BO1", {7'd0, bo1R}, 8'h00);

    $display("[TB] load clamping and limiting");
    applyStimulus(1'b1, 4'hF, 4'hB, 1'b0, 1'b0);
    cmp("clamp_FB", qR, 8'h20);
    applyStimulus(1'b1, 4'h0, 4'hC, 1'b1, 1'b1);
    cmp("clamp_0C", qR, 8'h09);
    applyStimulus(1'b1, 4'd1, 4'd9, 1'b0, 1'b1);

    $display("[TB] load beats terminal count");
    applyStimulus(1'b1, 4'd0, 4'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd0, 4'd5, 1'b1, 1'b1);
    cmp("priority_Q", qR, 8'h05);
    cmp("priority_DONE", {7'd0, doneR}, 8'h00);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);

    $display("[TB] asynchronous reset mid-count");
    applyStimulus(1'b1, 4'd1, 4'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    cmp("pre_reset_Q", qR, 8'h13);
    #3;
    CLR_N = 1'b0;
    #1;
    cmp("async_reset_Q_reload", qR, 8'h00);
    cmp("async_reset_Q_hold", qH, 8'h00);
    cmp("async_reset_DONE", {7'd0, doneR}, 8'h00);
    mR = 0;
    mH = 0;
    #2;
    CLR_N = 1'b1;
    ENP = 1'b0;
    ENT = 1'b0;
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    cmp("post_reset_BO2", {7'd0, bo2R}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Two-digit cascadable BCD down-counter (tens/ones), the count-down counterpart of the team's up-counting BCD20 counter.
- Used as a countdown timer or pre-set event counter.
- Synchronous parallel load of both digits; 74160-style ENP/ENT enables; combinational borrow outputs for cascading.
- Wraps to, or stops at, a parameterised start value.

Parameters:
- WRAP_VAL, 8'h20, BCD start/wrap value {tens,ones}. Each nibble must be ≤9; the compile-time check fails otherwise.
- AUTO_RELOAD, 1, 1 = 00 wraps to WRAP_VAL on the next count; 0 = counter holds at 00.

Ports:
- CLK  input  1  rising-edge clock.
- CLR_N  input  1  asynchronous active-low reset.
- LOAD  input  1  synchronous parallel load, active-high.
- DATA0  input  4  ones digit to load.
- DATA1  input  4  tens digit to load.
- ENP  input  1  count enable (parallel).
- ENT  input  1  count enable (trickle); also gates the borrow outputs.
- Q0  output  4  ones digit.
- Q1  output  4  tens digit.
- Q  output  8  {Q1,Q0}.
- BO1  output  1  ones-digit borrow (combinational).
- BO2  output  1  full-count borrow (combinational), used for cascading.
- DONE  output  1  registered one-cycle terminal pulse.

Behaviour:
- Reset: while CLR_N=0, asynchronously Q0=0, Q1=0, DONE=0. Release is synchronised by the usual reset-release practice, and the first edge after release acts normally.
- Priority per rising edge: LOAD > count > hold.
- Load (LOAD=1):
  - Each DATA nibble >9 is clamped to 9.
  - If the clamped value {d1,d0} exceeds WRAP_VAL as a BCD number, WRAP_VAL is loaded instead.
  - Load ignores ENP/ENT.
  - DONE=0 on a load cycle.
- Count condition: cnt = ENP & ENT & ~LOAD.
- Ones digit: on cnt, Q0 decrements; Q0=0 becomes 9.
- Tens digit: decrements only when cnt and Q0=0. Q1=0 with Q0=0 is the terminal state.
- Terminal state Q=00 with cnt:
  - AUTO_RELOAD=1: Q becomes WRAP_VAL.
  - AUTO_RELOAD=0: Q holds 00 and does not count further.
- DONE: registered.
  - 1 for exactly one cycle after the edge on which Q changed 01→00 by counting.
  - Never asserted by a load or by reset.
  - Held count at 00 (AUTO_RELOAD=0) does not re-pulse DONE.
- Borrow outputs (combinational, no ENP dependence, allowing cascade like the up-counter's RCO):
  - BO1 = ENT & (Q0==0).
  - BO2 = ENT & (Q==8'h00).
- Invalid internal state (nibble >9): unreachable by construction. The next count forces that digit to 9.
- Latency: Q updates on the same edge that samples LOAD/enables. Borrow outputs follow Q with zero cycles. DONE follows by one cycle.
- Simultaneous LOAD and terminal count: load wins, DONE=0.
- ENT=0: no counting, BO1=BO2=0 regardless of Q.

Decomposition:
- Package bcd_pkg:
  - BCD_MAX=4'd9, BCD_ZERO=4'd0.
  - typedef bcd_digit_t (4-bit).
  - Helper constant function that validates WRAP_VAL.
- Sub-module bcd_digit_down:
  - One decade down-counter with load, enable, clamp, and borrow-out (digit==0 & en).
  - Instantiated twice: the ones digit's borrow drives the tens digit's enable.
- Top level adds terminal/wrap logic, the WRAP_VAL compare, and DONE.

Test Plan:
- Reset: drive CLR_N=0 mid-count at Q=8'h13 → Q=00, DONE=0 immediately, without waiting for an edge. After release with ENP=ENT=0, Q stays 00 and BO2=0.
- Load and count: LOAD=1, DATA1=1, DATA0=2, then ENP=ENT=1 for 13 clocks → Q goes 12,11,10,09…01,00.
  - BO1=1 exactly at Q=10 and Q=00.
  - DONE pulses once, one cycle after Q=00.
- Wrap: with AUTO_RELOAD=1 at Q=00, count once → Q=8'h20. With AUTO_RELOAD=0 → Q holds 00 for 5 clocks, no further DONE.
- Clamp: load DATA1=4'hF, DATA0=4'hB → Q=8'h20 (9,9 clamped, then limited to WRAP_VAL). Load DATA1=0, DATA0=4'hC → Q=09.
- Enables: at Q=00, ENP=0, ENT=1 → Q holds, BO2=1. ENP=1, ENT=0 → Q holds, BO1=BO2=0.
- Priority: LOAD=1 with DATA=8'h05 on the same edge that Q=01 would count → Q=05, DONE stays 0.
